// File: rtl/alu_result_hilo.sv
// ---------------------------------------------------------------------------
// alu_result_hilo
//
// Output stage of the ALU datapath. Registers the result selected by the
// 6-bit function code (ALU result, shifter output, HI or LO), owns the HI/LO
// product registers and sequences the multi-cycle MULTU operation.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   Signal      6-bit function code
//   ALUOut      32-bit ALU result
//   ShifterOut  32-bit shifter result
//   MulAns      64-bit multiplier product, valid at the end of the busy window
//   dataOut     32-bit registered result to the register-file write port
//   busy        high while a MULTU is in progress
//   hilo_done   one-cycle pulse after HI/LO have been loaded
// ---------------------------------------------------------------------------
module alu_result_hilo #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Signal,
    input  logic [31:0] ALUOut,
    input  logic [31:0] ShifterOut,
    input  logic [63:0] MulAns,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        hilo_done
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic [31:0]      dout_q,  dout_d;
    logic             done_q,  done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dout_d  = dout_q;
        done_d  = 1'b0;

        if (state_q == S_IDLE) begin
            case (Signal)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: dout_d = ALUOut;
                OP_SRL:   dout_d = ShifterOut;
                OP_MFHI:  dout_d = hi_q;
                OP_MFLO:  dout_d = lo_q;
                OP_MULTU: begin
                    dout_d  = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
                default:  dout_d = '0;
            endcase
        end else begin
            // Signal is ignored and dataOut holds while the multiplier runs.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                hi_d    = MulAns[63:32];
                lo_d    = MulAns[31:0];
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    // busy is decoded purely from the state register.
    assign busy      = (state_q == S_MUL);
    assign dataOut   = dout_q;
    assign hilo_done = done_q;

endmodule

// File: tb/tb_alu_result_hilo.sv
module tb_alu_result_hilo;

    logic        clk;
    logic        reset;
    logic [5:0]  Signal;
    logic [31:0] ALUOut;
    logic [31:0] ShifterOut;
    logic [63:0] MulAns;
    logic [31:0] dataOut;
    logic        busy;
    logic        hilo_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    alu_result_hilo #(.MUL_CYCLES(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Signal     (Signal),
        .ALUOut     (ALUOut),
        .ShifterOut (ShifterOut),
        .MulAns     (MulAns),
        .dataOut    (dataOut),
        .busy       (busy),
        .hilo_done  (hilo_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge: drive one op, predict its result, check one cycle later.
    task automatic do_op(input string tag, input logic [5:0] sig, input logic [31:0] alu,
                         input logic [31:0] sh, input logic [31:0] expv);
        logic [31:0] e;
        Signal     = sig;
        ALUOut     = alu;
        ShifterOut = sh;
        exp_q.push_back(expv);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq(tag, {32'd0, dataOut}, {32'd0, e});
    endtask

    // Called at a negedge: issue MULTU, drive a distracting ALU op during the
    // busy window, and return at the negedge after busy falls.
    task automatic run_mul(input string tag, input logic [63:0] ans,
                           output int busy_cycles, output int done_cnt);
        int n;
        int dout_bad;
        busy_cycles = 0;
        done_cnt    = 0;
        dout_bad    = 0;
        n           = 0;
        Signal = 6'd25;
        MulAns = ans;
        @(negedge clk);
        Signal = 6'd32;
        ALUOut = 32'hDEAD_BEEF;
        while (busy === 1'b1 && n < 100) begin
            busy_cycles++;
            done_cnt += int'(hilo_done);
            if (dataOut !== 32'd0) dout_bad++;
            n++;
            @(negedge clk);
        end
        check_eq({tag, " busy_bound"}, {63'd0, (n < 100)}, 64'd1);
        check_eq({tag, " dout_held_zero_bad"}, 64'(dout_bad), 64'd0);
        done_cnt += int'(hilo_done);
    endtask

    initial begin
        int bc, dc, pulses;
        reset      = 1'b1;
        Signal     = 6'd0;
        ALUOut     = 32'd0;
        ShifterOut = 32'd0;
        MulAns     = 64'd0;
        repeat (3) @(negedge clk);
        check_eq("reset dataOut", {32'd0, dataOut}, 64'd0);
        check_eq("reset busy", {63'd0, busy}, 64'd0);
        check_eq("reset hilo_done", {63'd0, hilo_done}, 64'd0);
        reset = 1'b0;

        do_op("mfhi after reset", 6'd16, 32'h1111_1111, 32'h2222_2222, 32'd0);
        do_op("mflo after reset", 6'd18, 32'h1111_1111, 32'h2222_2222, 32'd0);
        check_eq("busy idle", {63'd0, busy}, 64'd0);

        do_op("add", 6'd32, 32'h0000_0007, 32'h0, 32'h0000_0007);
        do_op("srl", 6'd2,  32'h1234_5678, 32'h0F0F_0000, 32'h0F0F_0000);
        do_op("unknown63", 6'd63, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0);
        do_op("sub", 6'd34, 32'h8000_0001, 32'h0, 32'h8000_0001);
        do_op("and", 6'd36, 32'h00FF_00FF, 32'h0, 32'h00FF_00FF);
        do_op("unknown0", 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        do_op("or",  6'd37, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D);
        do_op("slt", 6'd42, 32'h0000_0001, 32'h0, 32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (i % 2 == 0) do_op("rand alu", 6'd32, r, ~r, r);
            else            do_op("rand srl", 6'd2, ~r, r, r);
        end

        run_mul("mul1", 64'h0000_0001_FFFF_FFFE, bc, dc);
        check_eq("mul1 busy cycles", 64'(bc), 64'd32);
        check_eq("mul1 done pulses", 64'(dc), 64'd1);
        do_op("mul1 mfhi", 6'd16, 32'h0, 32'h0, 32'h0000_0001);
        check_eq("mul1 done one cycle", {63'd0, hilo_done}, 64'd0);
        do_op("mul1 mflo", 6'd18, 32'h0, 32'h0, 32'hFFFF_FFFE);

        // Reset in the middle of a multiply.
        Signal = 6'd25;
        MulAns = 64'h0000_00AB_0000_00CD;
        @(negedge clk);
        Signal = 6'd0;
        repeat (9) @(negedge clk);
        check_eq("mid-mul busy before reset", {63'd0, busy}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("async reset busy", {63'd0, busy}, 64'd0);
        check_eq("async reset dataOut", {32'd0, dataOut}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        do_op("post-reset mflo", 6'd18, 32'h0, 32'h0, 32'd0);
        do_op("post-reset mfhi", 6'd16, 32'h0, 32'h0, 32'd0);
        Signal = 6'd0;
        for (int i = 0; i < 40; i++) begin
            pulses += int'(hilo_done);
            @(negedge clk);
        end
        check_eq("no done after reset", 64'(pulses), 64'd0);

        // Back-to-back multiplies.
        run_mul("mulA", 64'd5, bc, dc);
        check_eq("mulA busy cycles", 64'(bc), 64'd32);
        check_eq("mulA done pulses", 64'(dc), 64'd1);
        run_mul("mulB", 64'd9, bc, dc);
        check_eq("mulB busy cycles", 64'(bc), 64'd32);
        check_eq("mulB done pulses", 64'(dc), 64'd1);
        do_op("mulB mflo", 6'd18, 32'h0, 32'h0, 32'd9);
        do_op("mulB mfhi", 6'd16, 32'h0, 32'h0, 32'd0);
        do_op("final add", 6'd32, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
